// File: rtl/io_intc_pkg.sv
// rtl/io_intc_pkg.sv - shared constants and types for the io_intc interrupt controller
// Purpose: register word addresses, controller state encoding, interrupt id width.
// Ports: none (package).
package io_intc_pkg;

  localparam int ID_W = 4;

  localparam logic [13:0] ADDR_PEND  = 14'h3E88;
  localparam logic [13:0] ADDR_ENAB  = 14'h3E89;
  localparam logic [13:0] ADDR_MODE  = 14'h3E8A;
  localparam logic [13:0] ADDR_CLAIM = 14'h3E8B;
  localparam logic [13:0] ADDR_STAT  = 14'h3E8C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

endpackage

// File: rtl/intc_sync_edge.sv
// rtl/intc_sync_edge.sv - multi-flop synchronizer with rising-edge detect for one async line
// Purpose: bring an asynchronous interrupt line into the clk domain and flag 0->1 transitions.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   async_in     - raw asynchronous input
//   sync_out     - synchronized level (valid SYNC_STAGES edges after the input)
//   rise         - one-cycle pulse on a 0->1 transition of sync_out
module intc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // Arming shift register: the edge detector only trusts prev_q once both it
  // and the synchronizer hold real samples, so a line already high when reset
  // releases does not look like a fresh edge.
  logic [SYNC_STAGES:0]   arm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = arm_q[SYNC_STAGES] & sync_out & ~prev_q;

endmodule

// File: rtl/io_intc.sv
// rtl/io_intc.sv - memory-mapped interrupt controller with claim/complete handshake
// Purpose: latch, mask and prioritise the timer request and NUM_EXT external
//   lines, present one registered request to the CSR unit, and sit in the IO-bus
//   read chain behind the timer.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   dma_io_we/wadr/wdata            - register write port (word address)
//   dma_io_radr/radr_en             - register read port (word address)
//   dma_io_rdata_in / dma_io_rdata  - upstream read data in, chained read data out
//   timer_irq                       - timer level request (clk domain), id 1
//   ext_irq[NUM_EXT-1:0]            - asynchronous external lines, ids 2..NUM_EXT+1
//   csr_meie                        - global external-interrupt enable
//   int_req, int_id                 - registered request and requested/in-service id
module io_intc
  import io_intc_pkg::*;
#(
  parameter int NUM_EXT     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dma_io_we,
  input  logic [15:2]        dma_io_wadr,
  input  logic [31:0]        dma_io_wdata,
  input  logic [15:2]        dma_io_radr,
  input  logic               dma_io_radr_en,
  input  logic [31:0]        dma_io_rdata_in,
  output logic [31:0]        dma_io_rdata,
  input  logic               timer_irq,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               csr_meie,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id
);

  logic [NUM_EXT-1:0] ext_sync;
  logic [NUM_EXT-1:0] ext_rise;

  for (genvar g = 0; g < NUM_EXT; g++) begin : g_sync
    intc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (ext_irq[g]),
      .sync_out (ext_sync[g]),
      .rise     (ext_rise[g])
    );
  end

  // Bit i of the pending/enable/mode vectors belongs to id i+1; bit 0 is the timer.
  logic [NUM_EXT:0] enab_q;
  logic [NUM_EXT:1] mode_q;
  logic [NUM_EXT:1] pend_q;
  logic [NUM_EXT:1] pend_d;
  logic [NUM_EXT:0] pending;
  logic [NUM_EXT:0] active;

  intc_state_e     state_q, state_d;
  logic            int_req_d;
  logic [ID_W-1:0] int_id_d;
  logic [ID_W-1:0] win_id;
  logic            any_act;

  logic        rd_hit_q;
  logic [31:0] rd_data_q;
  logic [31:0] rd_mux;
  logic        rd_hit;

  logic unused_wdata;
  assign unused_wdata = ^dma_io_wdata[31:NUM_EXT+1];

  // The timer is already in the clk domain, so its pending bit is the live level.
  assign pending = {pend_q, timer_irq};
  assign active  = pending & enab_q;
  assign any_act = |active;

  wire wr_pend  = dma_io_we && (dma_io_wadr == ADDR_PEND);
  wire wr_enab  = dma_io_we && (dma_io_wadr == ADDR_ENAB);
  wire wr_mode  = dma_io_we && (dma_io_wadr == ADDR_MODE);
  wire claim_rd = dma_io_radr_en && (dma_io_radr == ADDR_CLAIM);
  wire claim    = claim_rd && (state_q == ST_REQ);
  wire complete = dma_io_we && (dma_io_wadr == ADDR_CLAIM) &&
                  (state_q == ST_SERVICE) && (dma_io_wdata[ID_W-1:0] == int_id);

  // Lowest id wins: scan from the top so the lowest active bit is written last.
  always_comb begin
    win_id = '0;
    for (int i = NUM_EXT; i >= 0; i--) begin
      if (active[i]) win_id = ID_W'(i + 1);
    end
  end

  // Edge bits: set beats clear, so an edge landing with a W1C or claim is kept.
  always_comb begin
    pend_d = pend_q;
    for (int i = 1; i <= NUM_EXT; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = ext_rise[i-1] |
                    (pend_q[i] & ~((wr_pend & dma_io_wdata[i]) |
                                   (claim & (int_id == ID_W'(i + 1)))));
      end else begin
        pend_d[i] = ext_sync[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enab_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_enab) enab_q <= dma_io_wdata[NUM_EXT:0];
      if (wr_mode) mode_q <= dma_io_wdata[NUM_EXT:1];
    end
  end

  // State register (also registers the request outputs).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      int_req <= 1'b0;
      int_id  <= '0;
    end else begin
      state_q <= state_d;
      int_req <= int_req_d;
      int_id  <= int_id_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (csr_meie && any_act) state_d = ST_REQ;
      ST_REQ: begin
        if (claim)                       state_d = ST_SERVICE;
        else if (!(csr_meie && any_act)) state_d = ST_IDLE;
      end
      ST_SERVICE: if (complete)          state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Outputs: in REQ the id tracks the current winner so a higher-priority
  // arrival preempts before claim; in SERVICE the claimed id is held.
  always_comb begin
    int_req_d = 1'b0;
    int_id_d  = '0;
    case (state_d)
      ST_REQ: begin
        int_req_d = 1'b1;
        int_id_d  = win_id;
      end
      ST_SERVICE: int_id_d = int_id;
      default: ;
    endcase
  end

  always_comb begin
    rd_hit = 1'b1;
    rd_mux = '0;
    case (dma_io_radr)
      ADDR_PEND:  rd_mux = 32'(pending);
      ADDR_ENAB:  rd_mux = 32'(enab_q);
      ADDR_MODE:  rd_mux = 32'({mode_q, 1'b0});
      ADDR_CLAIM: rd_mux = (state_q == ST_REQ) ? 32'(int_id) : 32'd0;
      ADDR_STAT:  rd_mux = {24'd0, int_id, state_q, int_req, csr_meie};
      default:    rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hit_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_hit_q <= dma_io_radr_en && rd_hit;
      if (dma_io_radr_en && rd_hit) rd_data_q <= rd_mux;
    end
  end

  assign dma_io_rdata = rd_hit_q ? rd_data_q : dma_io_rdata_in;

endmodule

// File: tb/tb_io_intc.sv
// tb/tb_io_intc.sv - self-checking bench for io_intc
// Purpose: per-cycle vector table for the register/handshake behaviour plus
//   hand sequences for reset, post-reset edges and read pass-through.
// Ports: none (top-level bench).
module tb_io_intc;

  localparam logic [13:0] A_PEND  = 14'h3E88;
  localparam logic [13:0] A_ENAB  = 14'h3E89;
  localparam logic [13:0] A_MODE  = 14'h3E8A;
  localparam logic [13:0] A_CLAIM = 14'h3E8B;
  localparam logic [13:0] A_STAT  = 14'h3E8C;
  localparam logic [31:0] RIN     = 32'hCAFE_F00D;

  logic        clk, rst_n;
  logic        we, re, tmr, meie;
  logic [13:0] wadr, radr;
  logic [31:0] wdata, rin, rdata;
  logic [3:0]  ext;
  logic        int_req;
  logic [3:0]  int_id;

  int n_cmp = 0;
  int n_bad = 0;

  io_intc #(.NUM_EXT(4), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dma_io_we       (we),
    .dma_io_wadr     (wadr),
    .dma_io_wdata    (wdata),
    .dma_io_radr     (radr),
    .dma_io_radr_en  (re),
    .dma_io_rdata_in (rin),
    .dma_io_rdata    (rdata),
    .timer_irq       (tmr),
    .ext_irq         (ext),
    .csr_meie        (meie),
    .int_req         (int_req),
    .int_id          (int_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [13:0] wadr;
    logic [31:0] wdata;
    logic        re;
    logic [13:0] radr;
    logic        tmr;
    logic [3:0]  ext;
    logic        meie;
    logic        exp_req;
    logic [3:0]  exp_id;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [13:0] wa, input logic [31:0] wd,
                     input logic r, input logic [13:0] ra, input logic t,
                     input logic [3:0] e, input logic m, input logic q,
                     input logic [3:0] id, input logic [31:0] rd);
    vec_t v;
    v = '{w, wa, wd, r, ra, t, e, m, q, id, rd};
    tv.push_back(v);
  endtask

  task automatic idle(input logic t, input logic [3:0] e, input logic m,
                      input logic q, input logic [3:0] id);
    add(0, 14'h0, 0, 0, 14'h0, t, e, m, q, id, RIN);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic t,
                    input logic [3:0] e, input logic m, input logic q, input logic [3:0] id);
    add(1, a, d, 0, 14'h0, t, e, m, q, id, RIN);
  endtask

  task automatic rd(input logic [13:0] a, input logic t, input logic [3:0] e,
                    input logic m, input logic q, input logic [3:0] id, input logic [31:0] x);
    add(0, 14'h0, 0, 1, a, t, e, m, q, id, x);
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1; wadr = a; wdata = d;
    @(negedge clk);
    we = 0;
  endtask

  task automatic bus_read(input logic [13:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    re = 1; radr = a;
    @(posedge clk);
    #1 check(name, rdata, exp);
    @(negedge clk);
    re = 0;
  endtask

  initial begin
    int   hit_at;
    rst_n = 0; we = 0; re = 0; tmr = 0; meie = 0; ext = 0;
    wadr = 0; radr = 0; wdata = 0; rin = RIN;
    repeat (3) @(negedge clk);
    check("reset int_req", 32'(int_req), 0);
    check("reset int_id", 32'(int_id), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // reset state of every register
    rd(A_PEND, 0, 0, 0, 0, 0, 0);
    rd(A_ENAB, 0, 0, 0, 0, 0, 0);
    rd(A_MODE, 0, 0, 0, 0, 0, 0);
    rd(A_CLAIM, 0, 0, 0, 0, 0, 0);
    rd(A_STAT, 0, 0, 0, 0, 0, 0);
    // timer request, claim, complete, re-raise
    wr(A_ENAB, 3, 0, 0, 1, 0, 0);
    idle(1, 0, 1, 1, 1);
    rd(A_CLAIM, 1, 0, 1, 0, 1, 1);
    rd(A_STAT, 1, 0, 1, 0, 1, 32'h19);
    wr(A_CLAIM, 1, 1, 0, 1, 0, 0);
    idle(1, 0, 1, 1, 1);
    idle(0, 0, 1, 0, 0);
    // edge source id 3, one-cycle pulse
    wr(A_MODE, 4, 0, 0, 1, 0, 0);
    wr(A_ENAB, 6, 0, 0, 1, 0, 0);
    idle(0, 4'b0010, 1, 0, 0);
    idle(0, 0, 1, 0, 0);
    idle(0, 0, 1, 0, 0);
    rd(A_PEND, 0, 0, 1, 1, 3, 4);
    rd(A_CLAIM, 0, 0, 1, 0, 3, 3);
    rd(A_PEND, 0, 0, 1, 0, 3, 0);
    wr(A_CLAIM, 3, 0, 0, 1, 0, 0);
    // ids 2 and 3 together, then service corner cases
    wr(A_MODE, 6, 0, 0, 1, 0, 0);
    idle(0, 4'b0011, 1, 0, 0);
    idle(0, 4'b0011, 1, 0, 0);
    idle(0, 0, 1, 0, 0);
    idle(0, 0, 1, 1, 2);
    rd(A_CLAIM, 0, 0, 1, 0, 2, 2);
    wr(A_CLAIM, 3, 0, 0, 1, 0, 2);
    rd(A_STAT, 0, 0, 1, 0, 2, 32'h29);
    rd(A_CLAIM, 0, 0, 1, 0, 2, 0);
    wr(A_CLAIM, 2, 0, 0, 1, 0, 0);
    idle(0, 0, 1, 1, 3);
    // id 2 edge during REQ for id 3 preempts before claim
    idle(0, 4'b0001, 1, 1, 3);
    idle(0, 4'b0001, 1, 1, 3);
    idle(0, 0, 1, 1, 3);
    idle(0, 0, 1, 1, 2);
    rd(A_CLAIM, 0, 0, 1, 0, 2, 2);
    wr(A_CLAIM, 2, 0, 0, 1, 0, 0);
    idle(0, 0, 1, 1, 3);
    rd(A_CLAIM, 0, 0, 1, 0, 3, 3);
    wr(A_CLAIM, 3, 0, 0, 1, 0, 0);
    rd(A_PEND, 0, 0, 1, 0, 0, 0);
    // meie low; W1C colliding with a new edge keeps the bit
    idle(0, 4'b0010, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    rd(A_PEND, 0, 4'b0010, 0, 0, 0, 4);
    idle(0, 0, 0, 0, 0);
    wr(A_PEND, 4, 0, 0, 0, 0, 0);
    rd(A_PEND, 0, 0, 0, 0, 0, 4);
    wr(A_PEND, 4, 0, 0, 0, 0, 0);
    rd(A_PEND, 0, 0, 0, 0, 0, 0);
    // into SERVICE with the timer for the reset check
    wr(A_ENAB, 7, 1, 0, 1, 0, 0);
    idle(1, 0, 1, 1, 1);
    rd(A_CLAIM, 1, 0, 1, 0, 1, 1);

    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      we = tv[k].we; wadr = tv[k].wadr; wdata = tv[k].wdata;
      re = tv[k].re; radr = tv[k].radr;
      tmr = tv[k].tmr; ext = tv[k].ext; meie = tv[k].meie;
      @(posedge clk);
      #1;
      check($sformatf("v%0d int_req", k), 32'(int_req), 32'(tv[k].exp_req));
      check($sformatf("v%0d int_id", k), 32'(int_id), 32'(tv[k].exp_id));
      check($sformatf("v%0d rdata", k), rdata, tv[k].exp_rd);
    end

    // asynchronous reset while in SERVICE
    @(negedge clk);
    we = 0; re = 0; tmr = 0; meie = 0;
    #2 rst_n = 0;
    #1;
    check("async reset int_req", 32'(int_req), 0);
    check("async reset int_id", 32'(int_id), 0);
    @(negedge clk);
    rst_n = 1;
    bus_read(A_PEND, 0, "post-reset PEND");
    bus_read(A_ENAB, 0, "post-reset ENAB");
    bus_read(A_MODE, 0, "post-reset MODE");
    bus_read(A_CLAIM, 0, "post-reset CLAIM");
    bus_read(A_STAT, 0, "post-reset STAT");

    // a line already high across reset gives no edge event
    @(negedge clk);
    rst_n = 0; ext = 4'b0010;
    repeat (2) @(negedge clk);
    rst_n = 1;
    bus_write(A_MODE, 4);
    bus_write(A_ENAB, 4);
    meie = 1;
    repeat (6) @(negedge clk);
    check("held-high line int_req", 32'(int_req), 0);
    bus_read(A_PEND, 0, "held-high line PEND");

    // a genuine edge afterwards requests id 3 four edges later
    ext = 0;
    repeat (4) @(negedge clk);
    ext = 4'b0010;
    hit_at = 0;
    for (int c = 1; c <= 10 && hit_at == 0; c++) begin
      @(posedge clk);
      #1 if (int_req) hit_at = c;
    end
    check("edge latency", 32'(hit_at), 4);
    check("edge id", 32'(int_id), 3);

    // unaddressed read passes the upstream data through
    @(negedge clk);
    rin = 32'hDEAD_BEEF; re = 1; radr = 14'h3E00;
    @(posedge clk);
    #1 check("pass-through", rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    re = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
